// File: rtl/sp_bus_pkg.sv
// Shared types and helpers for the SP bus bridge: FSM states, grant encoding,
// lane indexing and timeout counter sizing.
package sp_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BYTE,
        DONE
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    localparam int LANE_W    = 2;
    localparam int NUM_LANES = 4;

    // The wait counter only has to reach TIMEOUT-1 before the lane is aborted.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

    // Lowest lane index >= from whose select is set; lane k uses sel[3-k].
    // Result is {found, lane}.
    function automatic logic [LANE_W:0] find_lane(input logic [NUM_LANES-1:0] sel,
                                                  input logic [LANE_W:0] from);
        find_lane = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (k >= int'(from) && sel[NUM_LANES-1-k]) begin
                find_lane = {1'b1, LANE_W'(k)};
            end
        end
    endfunction

endpackage

// File: rtl/sp_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module sp_rr_arb
    import sp_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_i,
    input  logic       req_d,
    input  logic       update,
    output logic [1:0] gnt,
    output grant_e     last
);

    // gnt[0] selects the instruction bus, gnt[1] the data bus.
    always_comb begin
        gnt = '0;
        if (req_i && req_d) begin
            gnt = (last == GNT_I) ? 2'b10 : 2'b01;
        end else begin
            gnt = {req_d, req_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= GNT_I;
        end else if (update && (|gnt)) begin
            last <= gnt[1] ? GNT_D : GNT_I;
        end
    end

endmodule

// File: rtl/sp_bus_bridge.sv
// Bridges the instruction and data Wishbone32 masters onto one 8-bit external
// Wishbone port, one byte cycle per selected lane in big-endian lane order.
module sp_bus_bridge
    import sp_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_adr_i,
    input  logic        i_cyc_i,
    input  logic        i_stb_i,
    input  logic        i_we_i,
    input  logic [3:0]  i_sel_i,
    input  logic [31:0] i_dat_i,
    output logic [31:0] i_dat_o,
    output logic        i_ack_o,
    output logic        i_err_o,
    input  logic [31:0] d_adr_i,
    input  logic        d_cyc_i,
    input  logic        d_stb_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_dat_i,
    output logic [31:0] d_dat_o,
    output logic        d_ack_o,
    output logic        d_err_o,
    output logic [23:0] wb_adr_o,
    output logic [7:0]  wb_dat_o,
    input  logic [7:0]  wb_dat_i,
    output logic        wb_we_o,
    output logic        wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    state_e              state, state_next;
    grant_e              owner;
    logic [1:0]          gnt;
    logic                pick_d;
    logic [31:0]         adr_in, wdata_in;
    logic                we_in;
    logic [3:0]          sel_in;
    logic [21:0]         adr_q;
    logic                we_q;
    logic [3:0]          sel_q;
    logic [31:0]         wdata_q, rdata, rd_merged;
    logic [7:0]          wbyte;
    logic [LANE_W-1:0]   lane;
    logic [LANE_W:0]     first, nxt;
    logic [CNT_W-1:0]    wait_cnt;
    logic                timeout_hit, err_q, byte_active;
    logic [31:0]         i_hold, d_hold;
    logic                unused_adr;

    // Only the word address and the lane number reach the 24-bit bus.
    assign unused_adr = ^{i_adr_i[31:24], i_adr_i[1:0], d_adr_i[31:24], d_adr_i[1:0]};

    sp_rr_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_i  (i_cyc_i & i_stb_i),
        .req_d  (d_cyc_i & d_stb_i),
        .update (state == IDLE),
        .gnt    (gnt),
        .last   (owner)
    );

    assign pick_d   = gnt[1];
    assign adr_in   = pick_d ? d_adr_i : i_adr_i;
    assign we_in    = pick_d ? d_we_i  : i_we_i;
    assign sel_in   = pick_d ? d_sel_i : i_sel_i;
    assign wdata_in = pick_d ? d_dat_i : i_dat_i;

    assign first       = find_lane(sel_in, '0);
    assign nxt         = find_lane(sel_q, {1'b0, lane} + 3'd1);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign byte_active = (state == BYTE);

    always_comb begin
        rd_merged = rdata;
        wbyte     = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane == LANE_W'(k)) begin
                rd_merged[31-8*k -: 8] = wb_dat_i;
                wbyte                  = wdata_q[31-8*k -: 8];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (|gnt) state_next = (sel_in == '0) ? DONE : BYTE;
            BYTE: begin
                if (wb_ack_i) begin
                    state_next = nxt[LANE_W] ? BYTE : DONE;
                end else if (timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            wdata_q  <= '0;
            rdata    <= '0;
            lane     <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            i_hold   <= '0;
            d_hold   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (|gnt) begin
                    adr_q    <= adr_in[23:2];
                    we_q     <= we_in;
                    sel_q    <= sel_in;
                    wdata_q  <= wdata_in;
                    lane     <= first[LANE_W-1:0];
                    wait_cnt <= '0;
                    err_q    <= 1'b0;
                    rdata    <= '0;
                    // An empty-select read completes at once with zero data.
                    if (sel_in == '0 && !we_in) begin
                        if (pick_d) d_hold <= '0;
                        else        i_hold <= '0;
                    end
                end
                BYTE: begin
                    if (wb_ack_i) begin
                        wait_cnt <= '0;
                        rdata    <= rd_merged;
                        if (nxt[LANE_W]) begin
                            lane <= nxt[LANE_W-1:0];
                        end else if (!we_q) begin
                            if (owner == GNT_D) d_hold <= rd_merged;
                            else                i_hold <= rd_merged;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_cyc_o = byte_active;
    assign wb_stb_o = byte_active;
    assign wb_sel_o = byte_active;
    assign wb_we_o  = byte_active & we_q;
    assign wb_adr_o = byte_active ? {adr_q, lane} : '0;
    assign wb_dat_o = byte_active ? wbyte : '0;

    assign i_ack_o = (state == DONE) && (owner == GNT_I) && !err_q;
    assign i_err_o = (state == DONE) && (owner == GNT_I) && err_q;
    assign d_ack_o = (state == DONE) && (owner == GNT_D) && !err_q;
    assign d_err_o = (state == DONE) && (owner == GNT_D) && err_q;
    assign i_dat_o = i_hold;
    assign d_dat_o = d_hold;

endmodule

// File: tb/tb_sp_bus_bridge.sv
// Directed bench for sp_bus_bridge: reads, writes, arbitration, empty select,
// timeout and mid-transfer reset against a zero-wait combinational-ack slave.
module tb_sp_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_adr_i, i_dat_i, i_dat_o;
    logic        i_cyc_i, i_stb_i, i_we_i, i_ack_o, i_err_o;
    logic [3:0]  i_sel_i;
    logic [31:0] d_adr_i, d_dat_i, d_dat_o;
    logic        d_cyc_i, d_stb_i, d_we_i, d_ack_o, d_err_o;
    logic [3:0]  d_sel_i;
    logic [23:0] wb_adr_o;
    logic [7:0]  wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o, wb_ack_i;

    logic        slave_en;
    logic [31:0] rd_word;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    sp_bus_bridge #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .i_adr_i(i_adr_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_we_i(i_we_i),
        .i_sel_i(i_sel_i), .i_dat_i(i_dat_i), .i_dat_o(i_dat_o), .i_ack_o(i_ack_o),
        .i_err_o(i_err_o),
        .d_adr_i(d_adr_i), .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i),
        .d_sel_i(d_sel_i), .d_dat_i(d_dat_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
        .d_err_o(d_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    // Slave: acks every strobe in the same cycle, byte chosen by the address lane.
    assign wb_ack_i = slave_en & wb_stb_o;
    always_comb wb_dat_i = rd_word[8*(3-int'(wb_adr_o[1:0])) +: 8];

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_i(input logic req, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
        i_cyc_i = req; i_stb_i = req; i_we_i = we; i_sel_i = sel; i_adr_i = adr; i_dat_i = dat;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] dat);
        d_cyc_i = req; d_stb_i = req; d_we_i = we; d_sel_i = sel; d_adr_i = adr; d_dat_i = dat;
    endtask

    initial begin
        reset    = 1'b1;
        slave_en = 1'b1;
        rd_word  = 32'h11223344;
        set_i(0, 0, 4'h0, 32'h0, 32'h0);
        set_d(0, 0, 4'h0, 32'h0, 32'h0);
        tick(); tick(); tick();

        chk("rst_i_ack", {31'd0, i_ack_o}, 32'd0);
        chk("rst_d_err", {31'd0, d_err_o}, 32'd0);
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_adr", {8'd0, wb_adr_o}, 32'd0);
        chk("rst_d_dat", d_dat_o, 32'd0);
        reset = 1'b0;
        tick();

        // Word read on D
        set_d(1, 0, 4'hF, 32'h00001234, 32'h0);
        tick();
        chk("rd_lane0_adr", {8'd0, wb_adr_o}, 32'h001234);
        chk("rd_lane0_cyc", {31'd0, wb_cyc_o}, 32'd1);
        chk("rd_lane0_we", {31'd0, wb_we_o}, 32'd0);
        tick();
        chk("rd_lane1_adr", {8'd0, wb_adr_o}, 32'h001235);
        tick();
        chk("rd_lane2_adr", {8'd0, wb_adr_o}, 32'h001236);
        tick();
        chk("rd_lane3_adr", {8'd0, wb_adr_o}, 32'h001237);
        chk("rd_no_early_ack", {31'd0, d_ack_o}, 32'd0);
        tick();
        chk("rd_d_ack", {31'd0, d_ack_o}, 32'd1);
        chk("rd_i_ack", {31'd0, i_ack_o}, 32'd0);
        chk("rd_d_err", {31'd0, d_err_o}, 32'd0);
        chk("rd_d_dat", d_dat_o, 32'h11223344);
        chk("rd_done_cyc", {31'd0, wb_cyc_o}, 32'd0);
        set_d(0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("rd_ack_pulse", {31'd0, d_ack_o}, 32'd0);

        // Byte write on I
        set_i(1, 1, 4'b0010, 32'h00000100, 32'hAABBCCDD);
        tick();
        chk("wr_adr", {8'd0, wb_adr_o}, 32'h000102);
        chk("wr_dat", {24'd0, wb_dat_o}, 32'h0000_00CC);
        chk("wr_we", {31'd0, wb_we_o}, 32'd1);
        tick();
        chk("wr_i_ack", {31'd0, i_ack_o}, 32'd1);
        chk("wr_d_ack", {31'd0, d_ack_o}, 32'd0);
        chk("wr_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("wr_i_dat", i_dat_o, 32'd0);
        set_i(0, 0, 4'h0, 32'h0, 32'h0);
        tick();

        // Simultaneous repeating requests after reset: D, I, D, I
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_i(1, 0, 4'b1000, 32'h00000200, 32'h0);
        set_d(1, 0, 4'b0001, 32'h00000300, 32'h0);
        for (int r = 0; r < 4; r++) begin
            logic d_turn;
            d_turn = (r % 2 == 0);
            tick();
            chk($sformatf("rr%0d_adr", r), {8'd0, wb_adr_o}, d_turn ? 32'h000303 : 32'h000200);
            tick();
            chk($sformatf("rr%0d_d_ack", r), {31'd0, d_ack_o}, {31'd0, d_turn});
            chk($sformatf("rr%0d_i_ack", r), {31'd0, i_ack_o}, {31'd0, !d_turn});
            if (d_turn) chk($sformatf("rr%0d_d_dat", r), d_dat_o, 32'h00000044);
            else        chk($sformatf("rr%0d_i_dat", r), i_dat_o, 32'h11000000);
            if (r == 3) begin
                set_i(0, 0, 4'h0, 32'h0, 32'h0);
                set_d(0, 0, 4'h0, 32'h0, 32'h0);
            end
            tick();
            chk($sformatf("rr%0d_idle_cyc", r), {31'd0, wb_cyc_o}, 32'd0);
        end

        // Empty select read on D
        set_d(1, 0, 4'b0000, 32'h00000500, 32'h0);
        tick();
        chk("sel0_d_ack", {31'd0, d_ack_o}, 32'd1);
        chk("sel0_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("sel0_d_dat", d_dat_o, 32'd0);
        set_d(0, 0, 4'h0, 32'h0, 32'h0);
        tick();

        // Timeout: slave silent
        slave_en = 1'b0;
        set_d(1, 0, 4'hF, 32'h00000400, 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("to_stb%0d", c), {31'd0, wb_stb_o}, 32'd1);
            chk($sformatf("to_adr%0d", c), {8'd0, wb_adr_o}, 32'h000400);
        end
        tick();
        chk("to_d_err", {31'd0, d_err_o}, 32'd1);
        chk("to_d_ack", {31'd0, d_ack_o}, 32'd0);
        chk("to_i_err", {31'd0, i_err_o}, 32'd0);
        chk("to_stb_off", {31'd0, wb_stb_o}, 32'd0);
        set_d(0, 0, 4'h0, 32'h0, 32'h0);
        slave_en = 1'b1;
        tick();
        chk("to_err_pulse", {31'd0, d_err_o}, 32'd0);
        chk("to_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
        tick();
        chk("to_idle_cyc2", {31'd0, wb_cyc_o}, 32'd0);

        // Reset during lane 2, then a fresh request
        set_d(1, 0, 4'hF, 32'h00001234, 32'h0);
        tick(); tick(); tick();
        chk("mr_lane2_adr", {8'd0, wb_adr_o}, 32'h001236);
        reset = 1'b1;
        set_d(0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("mr_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("mr_d_ack", {31'd0, d_ack_o}, 32'd0);
        chk("mr_d_err", {31'd0, d_err_o}, 32'd0);
        reset = 1'b0;
        tick();
        chk("mr_post_ack", {31'd0, d_ack_o}, 32'd0);
        chk("mr_post_cyc", {31'd0, wb_cyc_o}, 32'd0);
        rd_word = 32'hA1B2C3D4;
        set_d(1, 0, 4'b0110, 32'h00001234, 32'h0);
        tick();
        chk("mr_new_adr1", {8'd0, wb_adr_o}, 32'h001235);
        tick();
        chk("mr_new_adr2", {8'd0, wb_adr_o}, 32'h001236);
        tick();
        chk("mr_new_ack", {31'd0, d_ack_o}, 32'd1);
        chk("mr_new_dat", d_dat_o, 32'h00B2C300);
        set_d(0, 0, 4'h0, 32'h0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
